// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared geometry, field widths, FSM encoding and helpers for the data cache.
package data_cache_pkg;
    localparam int LINES   = 4;
    localparam int WORDS   = 4;
    localparam int WORD_W  = 16;
    localparam int LINE_W  = WORDS * WORD_W;
    localparam int IDX_W   = 2;
    localparam int OFF_W   = 2;
    localparam int TAG_W   = 12;
    localparam int MADDR_W = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag/valid/dirty/data storage with per-word store merge and whole-line refill.
//   Clk, Reset_N      : clock, async active-low reset (clears valid/dirty only)
//   i_index, i_offset : line and word select for lookup and writes
//   i_word_we, i_wdata: store one word into the selected line and mark it dirty
//   i_line_we, i_line, i_tag : install a refilled line (valid=1, dirty=0)
//   o_valid, o_dirty, o_tag, o_line, o_word : contents of the selected line/word
module dcache_array
    import data_cache_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_N,
    input  logic [IDX_W-1:0]  i_index,
    input  logic [OFF_W-1:0]  i_offset,
    input  logic              i_word_we,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic              i_line_we,
    input  logic [LINE_W-1:0] i_line,
    input  logic [TAG_W-1:0]  i_tag,
    output logic              o_valid,
    output logic              o_dirty,
    output logic [TAG_W-1:0]  o_tag,
    output logic [LINE_W-1:0] o_line,
    output logic [WORD_W-1:0] o_word
);
    logic [LINE_W-1:0] r_data [LINES];
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_line_we) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_word_we) begin
            r_dirty[i_index] <= 1'b1;
        end
    end

    // Payload arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge Clk) begin
        if (i_line_we) begin
            r_data[i_index] <= i_line;
            r_tag[i_index]  <= i_tag;
        end else if (i_word_we) begin
            r_data[i_index][{i_offset, 4'b0000} +: WORD_W] <= i_wdata;
        end
    end

    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_line  = r_data[i_index];
    assign o_word  = r_data[i_index][{i_offset, 4'b0000} +: WORD_W];
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back/write-allocate data cache with miss FSM and perf counters.
//   Clk, Reset_N                 : clock, async active-low reset
//   d_readM, d_writeM            : MEM-stage load/store (both set = store)
//   d_address, d_wdata, d_rdata  : word address, store data, load data (0 unless read hit)
//   cacheStall                   : pipeline freeze while a miss is serviced
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack : line-level backing memory port
//   hit_count, access_count      : saturating performance counters
module data_cache
    import data_cache_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset_N,
    input  logic                d_readM,
    input  logic                d_writeM,
    input  logic [15:0]         d_address,
    input  logic [WORD_W-1:0]   d_wdata,
    output logic [WORD_W-1:0]   d_rdata,
    output logic                cacheStall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [MADDR_W-1:0]  mem_addr,
    output logic [LINE_W-1:0]   mem_wdata,
    input  logic [LINE_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic [15:0]         hit_count,
    output logic [15:0]         access_count
);
    state_t              r_state;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [MADDR_W-1:0]  r_mem_addr;
    logic [LINE_W-1:0]   r_mem_wdata;
    logic                r_missed;
    logic [15:0]         r_hit_cnt;
    logic [15:0]         r_acc_cnt;

    logic [TAG_W-1:0]    w_tag_in;
    logic [IDX_W-1:0]    w_index;
    logic [OFF_W-1:0]    w_offset;
    logic                w_access;
    logic                w_hit;
    logic                w_idle;
    logic                w_valid;
    logic                w_dirty;
    logic [TAG_W-1:0]    w_tag;
    logic [LINE_W-1:0]   w_line;
    logic [WORD_W-1:0]   w_word;

    assign w_tag_in   = d_address[15:4];
    assign w_index    = d_address[3:2];
    assign w_offset   = d_address[1:0];
    assign w_access   = d_readM | d_writeM;
    assign w_hit      = w_access & w_valid & (w_tag == w_tag_in);
    assign w_idle     = (r_state == IDLE);
    assign cacheStall = ~w_idle | (w_access & ~w_hit);
    assign d_rdata    = (w_idle & w_hit & ~d_writeM) ? w_word : '0;

    dcache_array u_array (
        .Clk       (Clk),
        .Reset_N   (Reset_N),
        .i_index   (w_index),
        .i_offset  (w_offset),
        .i_word_we (w_idle & w_hit & d_writeM),
        .i_wdata   (d_wdata),
        .i_line_we ((r_state == REFILL) & mem_ack),
        .i_line    (mem_rdata),
        .i_tag     (w_tag_in),
        .o_valid   (w_valid),
        .o_dirty   (w_dirty),
        .o_tag     (w_tag),
        .o_line    (w_line),
        .o_word    (w_word)
    );

    // Memory-side outputs are loaded on state entry and held until the
    // matching ack, so the memory sees a stable request.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_missed    <= 1'b0;
            r_hit_cnt   <= '0;
            r_acc_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_acc_cnt <= sat_inc(r_acc_cnt);
                        r_hit_cnt <= r_missed ? r_hit_cnt : sat_inc(r_hit_cnt);
                        r_missed  <= 1'b0;
                    end else if (w_access) begin
                        r_missed  <= 1'b1;
                        r_mem_req <= 1'b1;
                        if (w_valid & w_dirty) begin
                            r_state     <= WRITEBACK;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {w_tag, w_index};
                            r_mem_wdata <= w_line;
                        end else begin
                            r_state    <= REFILL;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= d_address[15:2];
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        r_state    <= REFILL;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= d_address[15:2];
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign hit_count    = r_hit_cnt;
    assign access_count = r_acc_cnt;
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed scoreboard bench for data_cache with a latency-programmable memory model.
module tb_data_cache;
    logic        Clk;
    logic        Reset_N;
    logic        d_readM;
    logic        d_writeM;
    logic [15:0] d_address;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        cacheStall;
    logic        mem_req;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_count;
    logic [15:0] access_count;

    logic        resp_ack;
    logic        man_ack;
    logic        resp_en;
    int          k;
    int          checks;
    int          errors;
    logic [63:0] mem_model [16384];

    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [63:0] wd;
    } txn_t;

    txn_t        exp_txn [$];
    logic [15:0] exp_rd [$];

    assign mem_ack   = resp_ack | man_ack;
    assign mem_rdata = mem_model[mem_addr];

    data_cache dut (
        .Clk          (Clk),
        .Reset_N      (Reset_N),
        .d_readM      (d_readM),
        .d_writeM     (d_writeM),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .cacheStall   (cacheStall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .hit_count    (hit_count),
        .access_count (access_count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: acks k cycles after each state entry and checks every
    // completed transfer against the expected-transaction queue.
    initial begin
        int cnt;
        txn_t t;
        resp_ack = 1'b0;
        cnt = 0;
        for (int i = 0; i < 16384; i++) mem_model[i] = {4{16'(i)}};
        mem_model[4]  = 64'h4444_3333_2222_1111;
        mem_model[20] = 64'h5D03_5D02_5D01_5D00;
        forever begin
            @(negedge Clk);
            resp_ack = 1'b0;
            if (resp_en && mem_req) begin
                cnt++;
                if (cnt >= k) begin
                    resp_ack = 1'b1;
                    cnt = 0;
                    chk("txn_expected", 64'(exp_txn.size() != 0), 64'd1);
                    if (exp_txn.size() != 0) begin
                        t = exp_txn.pop_front();
                        chk("txn_we", 64'(mem_we), 64'(t.we));
                        chk("txn_addr", 64'(mem_addr), 64'(t.addr));
                        if (t.we) chk("txn_wdata", mem_wdata, t.wd);
                    end
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic do_acc(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                          input logic [15:0] erd, input int est, input string tag);
        int st;
        @(negedge Clk);
        d_readM = rd;
        d_writeM = wr;
        d_address = a;
        d_wdata = wd;
        exp_rd.push_back(erd);
        #1;
        st = 0;
        while (cacheStall && st < 60) begin
            st++;
            @(negedge Clk);
            #1;
        end
        chk({tag, "_stall"}, 64'(st), 64'(est));
        chk({tag, "_rdata"}, 64'(d_rdata), 64'(exp_rd.pop_front()));
        @(posedge Clk);
        #1;
        d_readM = 1'b0;
        d_writeM = 1'b0;
    endtask

    task automatic chk_cnt(input string tag, input int acc, input int hit);
        chk({tag, "_access"}, 64'(access_count), 64'(acc));
        chk({tag, "_hit"}, 64'(hit_count), 64'(hit));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resp_en = 1'b1;
        man_ack = 1'b0;
        k = 3;
        Reset_N = 1'b0;
        d_readM = 1'b0;
        d_writeM = 1'b0;
        d_address = '0;
        d_wdata = '0;
        repeat (2) @(negedge Clk);
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_stall", 64'(cacheStall), 64'd0);
        chk_cnt("rst", 0, 0);
        Reset_N = 1'b1;

        exp_txn.push_back('{we: 1'b0, addr: 14'h0004, wd: '0});
        do_acc(1, 0, 16'h0013, 16'h0, 16'h4444, 4, "clean_miss");
        chk_cnt("clean_miss", 1, 0);
        do_acc(1, 0, 16'h0010, 16'h0, 16'h1111, 0, "read_hit");
        chk_cnt("read_hit", 2, 1);
        do_acc(0, 1, 16'h0011, 16'hBEEF, 16'h0, 0, "write_hit");
        chk_cnt("write_hit", 3, 2);
        do_acc(1, 1, 16'h0012, 16'h00AA, 16'h0, 0, "rw_store");
        chk_cnt("rw_store", 4, 3);

        k = 2;
        exp_txn.push_back('{we: 1'b1, addr: 14'h0004, wd: 64'h4444_00AA_BEEF_1111});
        exp_txn.push_back('{we: 1'b0, addr: 14'h0014, wd: '0});
        do_acc(1, 0, 16'h0051, 16'h0, 16'h5D01, 5, "dirty_miss");
        chk_cnt("dirty_miss", 5, 3);

        k = 1;
        exp_txn.push_back('{we: 1'b0, addr: 14'h0004, wd: '0});
        do_acc(1, 0, 16'h0011, 16'h0, 16'hBEEF, 2, "wb_roundtrip");
        chk_cnt("wb_roundtrip", 6, 3);
        exp_txn.push_back('{we: 1'b0, addr: 14'h0009, wd: '0});
        do_acc(0, 1, 16'h0026, 16'h1234, 16'h0, 2, "store_miss");
        do_acc(1, 0, 16'h0026, 16'h0, 16'h1234, 0, "store_merge");
        do_acc(1, 0, 16'h0024, 16'h0, 16'h0009, 0, "alloc_word0");
        chk_cnt("alloc", 9, 5);

        resp_en = 1'b0;
        @(negedge Clk);
        d_readM = 1'b1;
        d_address = 16'h0051;
        #1;
        chk("rr_miss_stall", 64'(cacheStall), 64'd1);
        @(negedge Clk);
        #1;
        chk("rr_refill_req", 64'(mem_req), 64'd1);
        chk("rr_refill_we", 64'(mem_we), 64'd0);
        chk("rr_refill_addr", 64'(mem_addr), 64'h14);
        Reset_N = 1'b0;
        #1;
        chk("rr_rst_req", 64'(mem_req), 64'd0);
        chk("rr_rst_we", 64'(mem_we), 64'd0);
        chk("rr_rst_stall_access", 64'(cacheStall), 64'd1);
        chk_cnt("rr_rst", 0, 0);
        d_readM = 1'b0;
        #1;
        chk("rr_rst_stall_idle", 64'(cacheStall), 64'd0);
        Reset_N = 1'b1;
        @(negedge Clk);
        man_ack = 1'b1;
        @(negedge Clk);
        man_ack = 1'b0;
        #1;
        chk("rr_stray_req", 64'(mem_req), 64'd0);
        chk("rr_stray_stall", 64'(cacheStall), 64'd0);

        resp_en = 1'b1;
        k = 3;
        exp_txn.push_back('{we: 1'b0, addr: 14'h0004, wd: '0});
        do_acc(1, 0, 16'h0011, 16'h0, 16'hBEEF, 4, "post_rst_miss");
        chk_cnt("post_rst_miss", 1, 0);
        do_acc(1, 0, 16'h0010, 16'h0, 16'h1111, 0, "post_rst_hit");
        chk_cnt("post_rst_hit", 2, 1);

        resp_en = 1'b0;
        @(negedge Clk);
        man_ack = 1'b1;
        @(negedge Clk);
        man_ack = 1'b0;
        #1;
        chk("idle_ack_req", 64'(mem_req), 64'd0);
        chk("idle_ack_stall", 64'(cacheStall), 64'd0);
        chk_cnt("idle_ack", 2, 1);
        resp_en = 1'b1;
        do_acc(1, 0, 16'h0010, 16'h0, 16'h1111, 0, "idle_ack_hit");
        chk_cnt("idle_ack_hit", 3, 2);

        repeat (2) @(negedge Clk);
        chk("txn_drained", 64'(exp_txn.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have port Clk  input  1  pipeline clock; all state changes on rising edge.
REQ-002 SHALL have port Reset_N  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port d_readM  input  1  MEM-stage load request.
REQ-004 SHALL have port d_writeM  input  1  MEM-stage store request.
REQ-005 SHALL have port d_address  input  16  word address; tag=[15:4], index=[3:2], offset=[1:0].
REQ-006 SHALL have port d_wdata  input  16  store data.
REQ-007 SHALL have port d_rdata  output  16  load data.
REQ-008 SHALL have port cacheStall  output  1  freeze request to pipeline control.
REQ-009 SHALL have port mem_req  output  1  backing-memory line request.
REQ-010 SHALL have port mem_we  output  1  1=line write-back, 0=line refill.
REQ-011 SHALL have port mem_addr  output  14  line address {tag,index}.
REQ-012 SHALL have port mem_wdata  output  64  victim line, word0 in [15:0].
REQ-013 SHALL have port mem_rdata  input  64  refill line, word0 in [15:0].
REQ-014 SHALL have port mem_ack  input  1  one-cycle completion pulse from memory.
REQ-015 SHALL have ports hit_count, access_count  output  16 each  performance counters.

Function
REQ-016 SHALL be direct-mapped, 4 lines x 4 16-bit words, write-back, write-allocate; per line: valid, dirty, 12-bit tag.
REQ-017 SHALL define access = d_readM|d_writeM; both asserted SHALL be treated as store.
REQ-018 SHALL define hit = access & valid[index] & (tag[index]==d_address[15:4]), evaluated combinationally.
REQ-019 SHALL use FSM states IDLE, WRITEBACK, REFILL.
REQ-020 SHALL compute cacheStall = (state!=IDLE) | (access & ~hit), combinationally.
REQ-021 Read hit in IDLE: d_rdata = addressed word same cycle, zero stall; d_rdata SHALL be 0x0000 when not a read hit.
REQ-022 Write hit in IDLE: addressed word <= d_wdata and dirty <= 1 at the rising edge; other words unchanged.
REQ-023 Miss in IDLE: next state WRITEBACK if victim valid&dirty, else REFILL.
REQ-024 WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag,index}, mem_wdata=victim line; on mem_ack -> REFILL.
REQ-025 REFILL: mem_req=1, mem_we=0, mem_addr=d_address[15:2]; on mem_ack line<=mem_rdata, valid<=1, dirty<=0, tag updated -> IDLE.
REQ-026 Pending access then re-evaluates in IDLE as a hit; a store merges d_wdata that cycle.
REQ-027 mem_req, mem_we, mem_addr, mem_wdata SHALL be registered-stable from state entry until mem_ack; mem_req=0 in IDLE.
REQ-028 mem_ack outside WRITEBACK/REFILL SHALL be ignored.
REQ-029 Latency: miss seen cycle T, ack k>=1 cycles after state entry; clean miss stall = k+1 cycles, dirty miss = k1+k2+1.
REQ-030 d_address/d_readM/d_writeM SHALL be held by the pipeline while cacheStall=1; the block need not latch them.
REQ-031 access_count SHALL increment once per completed access (IDLE & hit); hit_count only if no miss preceded it (internal missed flag); both saturate at 0xFFFF.

Reset
REQ-032 Reset_N low SHALL immediately force state=IDLE, valid=0, dirty=0 all lines, missed=0, counters=0, mem_req=0, mem_we=0, cacheStall follows REQ-020.
REQ-033 Reset mid-WRITEBACK/REFILL SHALL abandon the transfer; late mem_ack ignored.
REQ-034 Data and tag arrays need no reset.

Structure
REQ-035 Shared package SHALL hold line count, words/line, field widths, and state encoding.
REQ-036 Storage (tag/valid/dirty/data arrays, word-write merge) SHALL be one sub-module dcache_array; FSM and counters in data_cache.

Verification
REQ-037 Reset, load 0x0013, memory line 0x0004 = {0x4444,0x3333,0x2222,0x1111}, ack k=3 -> stall 4 cycles, d_rdata=0x4444, access=1, hit=0.
REQ-038 Then load 0x0010 -> no stall, d_rdata=0x1111, access=2, hit=1.
REQ-039 Store 0xBEEF to 0x0011 (hit) then load 0x0051 (same index, new tag) -> WRITEBACK mem_addr=0x0004, mem_wdata[31:16]=0xBEEF, then REFILL mem_addr=0x0014.
REQ-040 Simultaneous d_readM=d_writeM=1 at 0x0012 hit, d_wdata=0x00AA -> word stored, dirty=1, no stall.
REQ-041 Reset_N pulsed during REFILL, stray mem_ack after -> state IDLE, mem_req=0, next load to same line misses.
REQ-042 mem_ack pulsed in IDLE with no access -> no state, array, or counter change.
